// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: WIDTH-wide pipeline register stage with a valid/ready
// handshake and a 2-entry skid buffer. in_ready, out_valid and occ all come
// straight from flops, so out_ready has no combinational path to in_ready.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}},
  parameter bit               ZERO_BUBBLE = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ
);

  localparam int unsigned OCC_W = 2;

  // State encoding doubles as the occupancy count
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OCC_W-1:0] occ_q;
  logic             accept;
  logic             emit;

  // One transfer per side per edge
  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  // Next-state and data-path selection; flush discards any transfer this cycle
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = BUSY;
            main_nxt  = in_data;
          end
        end
        BUSY: begin
          if (accept && !emit) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (accept && emit) begin
            state_nxt = BUSY;
            main_nxt  = in_data;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_nxt = BUSY;
            main_nxt  = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register plus handshake/occupancy flops decoded from the next state
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      occ_q       <= OCC_W'(state_nxt);
    end
  end

  // Data registers: reset loads INIT, flush leaves contents alone
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      main_q <= INIT;
      skid_q <= INIT;
    end else begin
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign occ       = occ_q;
  assign out_data  = (ZERO_BUBBLE && !out_valid_q) ? INIT : main_q;

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline register stage with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and occupancy reporting. It replaces single-bit enable/clear flip-flops wherever the processor pipeline needs a WIDTH-wide latch, such as between fetch/decode/execute or in front of the plotter command path. It sustains full throughput (one transfer per cycle) while keeping `in_ready` a pure register output, so no combinational path runs from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, default 32: payload width in bits, ≥1.
- `INIT`, default `{WIDTH{1'b0}}`: value loaded into both data registers on reset.
- `ZERO_BUBBLE`, default 0: when 1, `out_data` is driven to `INIT` whenever `out_valid`=0; when 0, `out_data` holds the last main-register contents.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `clr_n`, input, 1: reset, synchronous, active-low.
- `flush`, input, 1: synchronous discard of all held entries.
- `in_valid`, input, 1: upstream presents `in_data`.
- `in_data`, input, WIDTH: upstream payload.
- `in_ready`, output, 1: stage can accept; registered.
- `out_valid`, output, 1: `out_data` is valid; registered.
- `out_data`, output, WIDTH: downstream payload.
- `out_ready`, input, 1: downstream accepts this cycle.
- `occ`, output, 2: entries held (0, 1, 2); registered.

## Operation
- Accept = `in_valid` & `in_ready`; emit = `out_valid` & `out_ready`; each is one transfer on that edge.
- Storage: main register (drives `out_data`) plus skid register; states EMPTY (occ 0), BUSY (occ 1), FULL (occ 2).
- EMPTY:
  - accept → BUSY, main ← `in_data`.
- BUSY:
  - accept & !emit → FULL, skid ← `in_data`.
  - accept & emit → BUSY, main ← `in_data`.
  - !accept & emit → EMPTY.
  - neither → hold.
- FULL (`in_ready`=0, no accept possible):
  - emit → BUSY, main ← skid.
  - else hold.
- Outputs by state:
  - `in_ready` = (state ≠ FULL).
  - `out_valid` = (state ≠ EMPTY).
  - `occ` encodes the state directly.
- Priority: `clr_n`=0 > `flush`=1 > normal handshake.
- Flush:
  - Next state EMPTY.
  - Any accept or emit in the flush cycle is discarded.
  - Data registers keep their contents (not reloaded with `INIT`).
- Reset:
  - State EMPTY; main and skid ← `INIT`.
  - Reset values: `out_valid`=0, `occ`=0, `in_ready`=1, `out_data`=`INIT`.
  - Transfers signalled while `clr_n`=0 are ignored.
- Order preserved; no entry duplicated or lost except by flush/reset.
- Data registers load only on the transfers listed above; no other data movement.

## Timing
- Latency: accept at edge N gives `out_valid`=1 with that data after edge N, visible in cycle N+1 (one cycle).
- Throughput: one accept and one emit per cycle in BUSY with both sides active; occupancy unchanged.
- `in_ready` drops the cycle after the accept that fills the skid register; it rises the cycle after the emit from FULL.
- Downstream stall holds `out_data` stable until emitted (no change while `out_valid` & !`out_ready`).
- `in_ready`, `out_valid` and `occ` are flop outputs. `out_data` is a flop output, or a flop output muxed with `INIT` when `ZERO_BUBBLE`=1.
- Reset or flush asserted mid-stream takes effect at that edge; the next cycle shows EMPTY outputs.

## Test plan
- Reset then idle, `WIDTH`=8, `INIT`=8'hA5: hold `clr_n`=0 for 2 cycles with `in_valid`=1. Afterwards require `out_valid`=0, `occ`=0, `in_ready`=1, `out_data`=8'hA5, and no data captured.
- Streaming: `out_ready`=1, send 8'h01..8'h10 back-to-back. Require outputs in order, each 1 cycle after acceptance, `in_ready` high throughout, `occ`=1 steady.
- Backpressure: send 8'h11, 8'h22, 8'h33 with `out_ready`=0.
  - Require `occ`=2 and `in_ready`=0 after the second accept; 8'h33 is held upstream.
  - Raise `out_ready`: require emission 8'h11, 8'h22, 8'h33 with no loss.
- Flush in FULL: hold 8'h44, 8'h55 with `flush`=1 and `in_valid`=1 (8'h66) in the same cycle. Next cycle require `occ`=0, `out_valid`=0, `in_ready`=1, and 8'h66 never emitted.
- `ZERO_BUBBLE`=1: emit the last entry. Next cycle require `out_data`=`INIT`. With `ZERO_BUBBLE`=0, require `out_data` still equals the emitted value.
- Random valid/ready (10k cycles) checked against a queue model: in-order, no loss or duplication. Also require `out_data` stable while stalled and `occ`≤2.
